// File: rtl/run_sequencer_pkg.sv
// Shared types and default addresses for the run sequencer.
// The watchdog is enabled with RUN_SEQ_WATCHDOG_EN.
package run_seq_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] FETCH  = 3'd4;
    localparam logic [2:0] REPORT = 3'd5;

    typedef logic [2:0] state_t;
    typedef logic [1:0] byte_idx_t;

    localparam logic [7:0] A_ADDR_DEF   = 8'd0;
    localparam logic [7:0] B_ADDR_DEF   = 8'd64;
    localparam logic [7:0] RES_ADDR_DEF = 8'd94;

endpackage

// File: rtl/run_sequencer_if.sv
// Job, core-control, data-memory and result signals of the run sequencer.
// master = sequencer side, slave = host/core/memory side.
interface run_sequencer_if;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        start;
    logic        done;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        res_valid;
    logic [31:0] result;
    logic [15:0] cycles;
    logic        timed_out;

    modport master (
        input  job_valid, op_a, op_b, done, mem_rdata,
        output job_ready, start, mem_we, mem_addr, mem_wdata,
        output res_valid, result, cycles, timed_out
    );

    modport slave (
        output job_valid, op_a, op_b, done, mem_rdata,
        input  job_ready, start, mem_we, mem_addr, mem_wdata,
        input  res_valid, result, cycles, timed_out
    );
endinterface

// File: rtl/run_sequencer_sat_counter.sv
// 16-bit up counter with clear (priority) and enable, sticking at 0xFFFF.
module sat_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 16'd0;
        else if (en_i && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/run_sequencer.sv
// Loads operands into core memory, launches the core, times it, reads back the result.
// Optional run watchdog: define RUN_SEQ_WATCHDOG_EN.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter logic [7:0] A_ADDR       = A_ADDR_DEF,
    parameter logic [7:0] B_ADDR       = B_ADDR_DEF,
    parameter logic [7:0] RES_ADDR     = RES_ADDR_DEF,
    parameter int         START_CYCLES = 2,
    parameter int         TIMEOUT      = 4096
) (
    input logic             CLK,
    input logic             Reset,
    run_sequencer_if.master bus
);
    state_t      state_q, state_d;
    byte_idx_t   idx_q, idx_d;
    logic [15:0] opa_q, opb_q;
    logic [23:0] sh_q;
    logic [31:0] result_q;
    logic [15:0] cycles_q;
    logic        to_q;
    logic [15:0] cnt;
    logic        cnt_clr, cnt_en, to_hit;
    logic [15:0] op_sel;

    sat_counter u_cnt (
        .clk_i (CLK),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

`ifndef RUN_SEQ_WATCHDOG_EN
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                if (bus.job_valid) state_d = LOAD;
            end
            LOAD: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = LAUNCH;
                    cnt_clr = 1'b1;
                end
            end
            LAUNCH: begin
                cnt_en = 1'b1;
                if (cnt == 16'(START_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                idx_d = 2'd0;
                if (bus.done) begin
                    state_d = FETCH;
                end else begin
                    cnt_en = 1'b1;
`ifdef RUN_SEQ_WATCHDOG_EN
                    if (cnt == 16'(TIMEOUT - 1)) begin
                        to_hit  = 1'b1;
                        state_d = REPORT;
                    end
`endif
                end
            end
            FETCH: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = REPORT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            opa_q    <= 16'd0;
            opb_q    <= 16'd0;
            sh_q     <= 24'd0;
            result_q <= 32'd0;
            cycles_q <= 16'd0;
            to_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && bus.job_valid) begin
                opa_q <= bus.op_a;
                opb_q <= bus.op_b;
            end
            if (state_q == FETCH) begin
                case (idx_q)
                    2'd0: sh_q[7:0]   <= bus.mem_rdata;
                    2'd1: sh_q[15:8]  <= bus.mem_rdata;
                    2'd2: sh_q[23:16] <= bus.mem_rdata;
                    default: begin
                        result_q <= {bus.mem_rdata, sh_q};
                        cycles_q <= cnt;
                        to_q     <= 1'b0;
                    end
                endcase
            end
            // Watchdog abort reports the count including the final cycle.
            if (to_hit) begin
                result_q <= 32'd0;
                cycles_q <= cnt + 16'd1;
                to_q     <= 1'b1;
            end
        end
    end

    assign op_sel = idx_q[1] ? opb_q : opa_q;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 8'h00;
        unique case (1'b1)
            (state_q == LOAD): begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = (idx_q[1] ? B_ADDR : A_ADDR)
                              + {7'd0, idx_q[0]};
                bus.mem_wdata = idx_q[0] ? op_sel[15:8] : op_sel[7:0];
            end
            (state_q == FETCH): begin
                bus.mem_addr = RES_ADDR + {6'd0, idx_q};
            end
            default: ;
        endcase
    end

    assign bus.job_ready = (state_q == IDLE);
    assign bus.start     = (state_q == IDLE) || (state_q == LOAD)
                        || (state_q == LAUNCH);
    assign bus.res_valid = (state_q == REPORT);
    assign bus.result    = result_q;
    assign bus.cycles    = cycles_q;
    assign bus.timed_out = to_q;
endmodule
